// File: rtl/wb_pkg.sv
// Shared widths, requester identifiers and request record for the writeback arbiter.
package wb_pkg;

    localparam int WB_NREQ = 4;
    localparam int WB_XLEN = 32;
    localparam int WB_AW   = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_FPU = 2'd1,
        WB_LSU = 2'd2,
        WB_IO  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [WB_AW-1:0]   addr;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod N.
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int N = WB_NREQ
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            // ptr + i is below 2N, so one conditional subtract gives the modulo
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(N)) sum = sum - SW'(N);
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin share of the regfile write port with a registered write stage.
// Optional pending-destination tracking under macro WBARB_SCOREBOARD_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int XLEN = WB_XLEN,
    parameter int AW   = WB_AW
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
`ifdef WBARB_SCOREBOARD_EN
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic [(2**AW)-1:0]   busy,
`endif
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [XLEN-1:0]      rf_wd
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            any;
    logic            hs;
    logic            wr;
    logic [AW-1:0]   g_addr;
    logic [XLEN-1:0] g_data;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // rstn gates ready so no requester sees a handshake while reset is held
    assign req_ready = gnt & {NREQ{~flush & rstn}};
    assign hs        = any & ~flush & rstn;
    assign g_addr    = req_addr[gnt_idx*AW +: AW];
    assign g_data    = req_data[gnt_idx*XLEN +: XLEN];
    assign wr        = hs && (g_addr != '0);
    assign ptr_nxt   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr   <= '0;
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= wr;
            if (hs) ptr <= ptr_nxt;
            if (wr) begin
                rf_wa <= g_addr;
                rf_wd <= g_data;
            end
        end
    end

`ifdef WBARB_SCOREBOARD_EN
    logic [(2**AW)-1:0] busy_nxt;

    // clear before set so a same-cycle reissue of the committing register stays busy
    always_comb begin
        busy_nxt = busy;
        if (rf_we) busy_nxt[rf_wa] = 1'b0;
        if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      busy <= '0;
        else if (flush) busy <= '0;
        else            busy <= busy_nxt;
    end
`else
    // no pending-destination tracking in this build; arbitration is unchanged
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus hand sequences for reset, flush and busy tracking.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int A  = 5;
    localparam int NROW = 15;

    logic            clk;
    logic            rstn;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*A-1:0]  req_addr;
    logic [N*XL-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [A-1:0]    rf_wa;
    logic [XL-1:0]   rf_wd;
`ifdef WBARB_SCOREBOARD_EN
    logic            issue_valid;
    logic [A-1:0]    issue_rd;
    logic [31:0]     busy;
`endif

    wb_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
`ifdef WBARB_SCOREBOARD_EN
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
`endif
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            flush;
        logic [N-1:0]    valid;
        logic [N-1:0]    rdy;
        logic [N-1:0][A-1:0] addr;
    } vec_t;

    typedef struct {
        logic          we;
        logic [A-1:0]  wa;
        logic [XL-1:0] wd;
    } wr_t;

    vec_t  tbl [NROW];
    wr_t   sbq [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [A-1:0]  hold_wa = '0;
    logic [XL-1:0] hold_wd = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*XL-1:0] mkdata(input int r);
        logic [N*XL-1:0] d;
        for (int i = 0; i < N; i++) d[i*XL +: XL] = 32'hC0DE_0000 + 32'(r << 8) + 32'(i);
        return d;
    endfunction

    // called at posedge+1: apply inputs, check ready mid-cycle, then check the registered write
    task automatic cycle(input string nm, input logic f, input logic [N-1:0] v,
                         input logic [N*A-1:0] ad, input logic [N*XL-1:0] dt,
                         input logic [N-1:0] exp_rdy);
        wr_t e;
        wr_t got;
        flush     = f;
        req_valid = v;
        req_addr  = ad;
        req_data  = dt;
        @(negedge clk);
        chk({nm, " ready"}, 64'(req_ready), 64'(exp_rdy));
        e.we = 1'b0;
        e.wa = hold_wa;
        e.wd = hold_wd;
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i] && ad[i*A +: A] != '0) begin
                e.we = 1'b1;
                e.wa = ad[i*A +: A];
                e.wd = dt[i*XL +: XL];
            end
        end
        hold_wa = e.wa;
        hold_wd = e.wd;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        chk({nm, " rf_we"}, 64'(rf_we), 64'(got.we));
        chk({nm, " rf_wa"}, 64'(rf_wa), 64'(got.wa));
        chk({nm, " rf_wd"}, 64'(rf_wd), 64'(got.wd));
    endtask

    initial begin
        logic [N-1:0][A-1:0] ad;
        logic [N*XL-1:0]     dt;

        // expected grants derived by hand, pointer = 2 after the single-request sequence
        tbl[0]  = '{1'b0, 4'b1111, 4'b0100, '0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1000, '0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0001, '0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0010, '0};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0100, '0};
        tbl[5]  = '{1'b0, 4'b0001, 4'b0001, '0};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0100, '0};
        tbl[7]  = '{1'b0, 4'b0011, 4'b0001, '0};
        tbl[8]  = '{1'b0, 4'b0010, 4'b0010, '0};
        tbl[9]  = '{1'b1, 4'b0001, 4'b0000, '0};
        tbl[10] = '{1'b0, 4'b0001, 4'b0001, '0};
        tbl[11] = '{1'b0, 4'b1001, 4'b1000, '0};
        tbl[12] = '{1'b0, 4'b1010, 4'b0010, '0};
        tbl[13] = '{1'b0, 4'b0011, 4'b0001, '0};
        tbl[14] = '{1'b0, 4'b0000, 4'b0000, '0};
        for (int r = 0; r < NROW; r++)
            for (int i = 0; i < N; i++) tbl[r].addr[i] = A'(8 + i + r);
        tbl[6].addr[2] = '0;

        rstn      = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        req_data  = mkdata(99);
`ifdef WBARB_SCOREBOARD_EN
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
`endif
        #2;
        chk("reset ready", 64'(req_ready), 64'h0);
        chk("reset rf_we", 64'(rf_we), 64'h0);
        @(posedge clk);
        #1;
        chk("reset rf_we edge", 64'(rf_we), 64'h0);
        chk("reset rf_wa edge", 64'(rf_wa), 64'h0);
        chk("reset rf_wd edge", 64'(rf_wd), 64'h0);
`ifdef WBARB_SCOREBOARD_EN
        chk("reset busy", 64'(busy), 64'h0);
        issue_valid = 1'b0;
`endif
        req_valid = '0;
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        ad = '0;
        ad[int'(WB_FPU)] = 5'd7;
        dt = '0;
        dt[int'(WB_FPU)*XL +: XL] = 32'hDEAD_BEEF;
        cycle("single", 1'b0, 4'b0010, ad, dt, 4'b0010);

        for (int r = 0; r < NROW; r++)
            cycle($sformatf("row%0d", r), tbl[r].flush, tbl[r].valid, tbl[r].addr, mkdata(r), tbl[r].rdy);

`ifdef WBARB_SCOREBOARD_EN
        ad = '0;
        ad[1] = 5'd9;
        ad[2] = 5'd9;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        cycle("sb issue", 1'b0, 4'b0000, ad, mkdata(40), 4'b0000);
        issue_valid = 1'b0;
        chk("sb set", 64'(busy[9]), 64'h1);
        cycle("sb wb", 1'b0, 4'b0010, ad, mkdata(41), 4'b0010);
        chk("sb pending", 64'(busy[9]), 64'h1);
        cycle("sb commit", 1'b0, 4'b0000, ad, mkdata(42), 4'b0000);
        chk("sb cleared", 64'(busy[9]), 64'h0);
        issue_valid = 1'b1;
        cycle("sb reissue", 1'b0, 4'b0000, ad, mkdata(43), 4'b0000);
        issue_valid = 1'b0;
        cycle("sb wb2", 1'b0, 4'b0100, ad, mkdata(44), 4'b0100);
        issue_valid = 1'b1;
        cycle("sb set wins", 1'b0, 4'b0000, ad, mkdata(45), 4'b0000);
        chk("sb set wins busy", 64'(busy[9]), 64'h1);
        issue_rd = 5'd0;
        cycle("sb x0", 1'b0, 4'b0000, ad, mkdata(46), 4'b0000);
        chk("sb x0 busy", 64'(busy), 64'h200);
        issue_rd = 5'd5;
        cycle("sb flush", 1'b1, 4'b0000, ad, mkdata(47), 4'b0000);
        issue_valid = 1'b0;
        chk("sb flush busy", 64'(busy), 64'h0);
        issue_rd = 5'd12;
        issue_valid = 1'b1;
`endif

        // async reset while a write is registered
        ad = '0;
        ad[1] = 5'd12;
        cycle("arst pre", 1'b0, 4'b0010, ad, mkdata(50), 4'b0010);
        req_valid = '0;
`ifdef WBARB_SCOREBOARD_EN
        issue_valid = 1'b0;
        chk("arst busy pre", 64'(busy[12]), 64'h1);
`endif
        #2;
        rstn = 1'b0;
        #1;
        chk("arst rf_we", 64'(rf_we), 64'h0);
        chk("arst rf_wa", 64'(rf_wa), 64'h0);
        chk("arst rf_wd", 64'(rf_wd), 64'h0);
`ifdef WBARB_SCOREBOARD_EN
        chk("arst busy", 64'(busy), 64'h0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("arst after rf_we", 64'(rf_we), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
